// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone master arbiter: FSM states, default watchdog limit, index width helper.
// No logic; latency and backpressure are defined by the modules that import it.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT = 255;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Round-robin picker: first requester scanning upward from last+1 (mod NM), one-hot and index out.
// Purely combinational, zero latency; no backpressure, it only observes the request vector.
module wb_arb_rr_pick #(
  parameter int NM = 4,
  parameter int IW = 2
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] last_i,
  output logic [NM-1:0] gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    // k = NM wraps back to last itself, so a lone requester equal to last still wins
    for (int k = 1; k <= NM; k++) begin
      cand = IW'((int'(last_i) + k) % NM);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter of NM Wishbone masters onto one master port; grant 1 cycle after request, held for the whole cyc.
// Ack/err/data paths are combinational; losers simply wait with cyc high. Watchdog abort enabled by WB_ARB_TIMEOUT_EN.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NM      = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NM-1:0]      wbm_cyc_i,
  input  logic [NM-1:0]      wbm_stb_i,
  input  logic [NM-1:0]      wbm_we_i,
  input  logic [NM*DW/8-1:0] wbm_sel_i,
  input  logic [NM*AW-1:0]   wbm_adr_i,
  input  logic [NM*DW-1:0]   wbm_dat_i,
  output logic [DW-1:0]      wbm_dat_o,
  output logic [NM-1:0]      wbm_ack_o,
  output logic [NM-1:0]      wbm_err_o,
  output logic               wbs_cyc_o,
  output logic               wbs_stb_o,
  output logic               wbs_we_o,
  output logic [DW/8-1:0]    wbs_sel_o,
  output logic [AW-1:0]      wbs_adr_o,
  output logic [DW-1:0]      wbs_dat_o,
  input  logic [DW-1:0]      wbs_dat_i,
  input  logic               wbs_ack_i,
  output logic [NM-1:0]      grant_o
);

  localparam int SEL = DW / 8;
  localparam int IW  = idx_w(NM);

  arb_state_e    state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] last_q, last_d;

  logic [NM-1:0] pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          own_cyc;
  logic          own_stb;
  logic          slv_en;
  logic          abort;

  wb_arb_rr_pick #(
    .NM (NM),
    .IW (IW)
  ) u_pick (
    .req_i  (wbm_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  assign own_cyc = wbm_cyc_i[gidx_q];
  assign own_stb = wbm_stb_i[gidx_q];

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);

  logic [TW-1:0] wd_q, wd_d;

  assign abort = (state_q == ST_GRANT) && (wd_q == TW'(TIMEOUT));

  // Cleared outside GRANT so every new grant starts from zero
  always_comb begin
    wd_d = wd_q;
    if (state_q != ST_GRANT || wbs_ack_i) begin
      wd_d = '0;
    end else if (own_stb && !abort) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign wbm_err_o = abort ? grant_q : '0;
`else
  assign abort     = 1'b0;
  assign wbm_err_o = '0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|wbm_cyc_i) begin
          state_d = ST_GRANT;
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
        end
      end
      ST_GRANT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end else if (abort) begin
          state_d = ST_ABORT;
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_ABORT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NM - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

  // Slave side is driven only while a live grant exists; zero in IDLE, ABORT and reset
  assign slv_en    = (state_q == ST_GRANT) && !abort;
  assign wbs_cyc_o = slv_en & own_cyc;
  assign wbs_stb_o = slv_en & own_stb;
  assign wbs_we_o  = slv_en & wbm_we_i[gidx_q];
  assign wbs_sel_o = slv_en ? wbm_sel_i[gidx_q*SEL +: SEL] : '0;
  assign wbs_adr_o = slv_en ? wbm_adr_i[gidx_q*AW +: AW]   : '0;
  assign wbs_dat_o = slv_en ? wbm_dat_i[gidx_q*DW +: DW]   : '0;

  assign wbm_ack_o = (slv_en && wbs_ack_i) ? grant_q : '0;
  assign wbm_dat_o = wbs_dat_i;
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: reset, single master, fairness, burst hold, mid-cycle reset, watchdog.
// Expected values are hand-derived constants.
module tb_wb_master_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NM  = 4;
  localparam int SEL = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*SEL-1:0] m_sel;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack, m_err, grant;
  logic              s_cyc, s_stb, s_we, s_ack;
  logic [SEL-1:0]    s_sel;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_o, s_dat_i;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .NM      (NM),
    .TIMEOUT (16)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wbm_cyc_i (m_cyc),
    .wbm_stb_i (m_stb),
    .wbm_we_i  (m_we),
    .wbm_sel_i (m_sel),
    .wbm_adr_i (m_adr),
    .wbm_dat_i (m_dat),
    .wbm_dat_o (m_dat_o),
    .wbm_ack_o (m_ack),
    .wbm_err_o (m_err),
    .wbs_cyc_o (s_cyc),
    .wbs_stb_o (s_stb),
    .wbs_we_o  (s_we),
    .wbs_sel_o (s_sel),
    .wbs_adr_o (s_adr),
    .wbs_dat_o (s_dat_o),
    .wbs_dat_i (s_dat_i),
    .wbs_ack_i (s_ack),
    .grant_o   (grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow after another unit of settling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_m(input int m, input logic c, input logic s, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_cyc[m]              = c;
    m_stb[m]              = s;
    m_we[m]               = w;
    m_sel[m*SEL +: SEL]   = {SEL{1'b1}};
    m_adr[m*AW +: AW]     = a;
    m_dat[m*DW +: DW]     = d;
  endtask

  initial begin
    logic [NM-1:0] exp_g;
    rst_n   = 1'b0;
    m_cyc   = '0;
    m_stb   = '0;
    m_we    = '0;
    m_sel   = '0;
    m_adr   = '0;
    m_dat   = '0;
    s_ack   = 1'b0;
    s_dat_i = '0;

    // Reset held for two edges with every master requesting
    m_cyc = '1;
    m_stb = '1;
    m_adr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0010};
    tick();
    tick();
    s_dat_i = 32'h1234_5678;
    s_ack   = 1'b1;
    settle();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_cyc", s_cyc, 1'b0);
    chk("rst_stb", s_stb, 1'b0);
    chk("rst_adr", s_adr, 32'h0);
    chk("rst_ack", m_ack, 4'b0000);
    chk("rst_err", m_err, 4'b0000);
    chk("rst_dat_passthru", m_dat_o, 32'h1234_5678);
    s_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    settle();
    chk("first_grant_m0", grant, 4'b0001);
    chk("first_cyc", s_cyc, 1'b1);
    chk("first_adr", s_adr, 32'h0000_0010);
    m_cyc = '0;
    m_stb = '0;
    settle();
    chk("drop_cyc_comb", s_cyc, 1'b0);
    tick();
    settle();
    chk("release_grant", grant, 4'b0000);

    // Master 2 writes then reads back within one cyc
    drive_m(2, 1'b1, 1'b1, 1'b1, 32'h2300_0000, 32'hDEAD_BEEF);
    tick();
    settle();
    chk("m2_grant", grant, 4'b0100);
    chk("m2_cyc", s_cyc, 1'b1);
    chk("m2_stb", s_stb, 1'b1);
    chk("m2_we", s_we, 1'b1);
    chk("m2_adr", s_adr, 32'h2300_0000);
    chk("m2_wdat", s_dat_o, 32'hDEAD_BEEF);
    chk("m2_sel", s_sel, 4'hF);
    s_ack = 1'b1;
    settle();
    chk("m2_wr_ack", m_ack, 4'b0100);
    tick();
    s_ack   = 1'b0;
    m_we[2] = 1'b0;
    settle();
    chk("m2_rd_noack", m_ack, 4'b0000);
    chk("m2_rd_we", s_we, 1'b0);
    tick();
    s_ack   = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    settle();
    chk("m2_rd_ack", m_ack, 4'b0100);
    chk("m2_rd_dat", m_dat_o, 32'hDEAD_BEEF);
    chk("m2_rd_adr", s_adr, 32'h2300_0000);
    tick();
    s_ack = 1'b0;
    drive_m(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("m2_drop_cyc", s_cyc, 1'b0);
    tick();
    settle();
    chk("m2_release", grant, 4'b0000);

    // Fairness from a fresh reset: all four request, one transfer per cyc
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_cyc = '1;
    m_stb = '1;
    for (int i = 0; i < 6; i++) begin
      exp_g = 4'b0001 << (i % NM);
      tick();
      settle();
      chk($sformatf("rr_grant_%0d", i), grant, exp_g);
      s_ack = 1'b1;
      settle();
      chk($sformatf("rr_ack_%0d", i), m_ack, exp_g);
      tick();
      s_ack            = 1'b0;
      m_cyc[i % NM]    = 1'b0;
      m_stb[i % NM]    = 1'b0;
      settle();
      chk($sformatf("rr_dropcyc_%0d", i), s_cyc, 1'b0);
      tick();
      m_cyc[i % NM] = 1'b1;
      m_stb[i % NM] = 1'b1;
      settle();
      chk($sformatf("rr_dead_%0d", i), grant, 4'b0000);
    end
    m_cyc = '0;
    m_stb = '0;
    tick();

    // Burst hold: master 1 keeps the bus for four transfers while master 0 waits
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h1000_0040, 32'h0);
    tick();
    settle();
    chk("burst_grant_m1", grant, 4'b0010);
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1;
      settle();
      chk($sformatf("burst_ack_%0d", b), m_ack, 4'b0010);
      tick();
      s_ack = 1'b0;
      settle();
      chk($sformatf("burst_hold_%0d", b), grant, 4'b0010);
      tick();
    end
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    settle();
    chk("burst_dead", grant, 4'b0000);
    tick();
    settle();
    chk("burst_next_m0", grant, 4'b0001);
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Reset while master 3 is granted with stb high
    drive_m(3, 1'b1, 1'b1, 1'b1, 32'h3000_0010, 32'h5555_AAAA);
    tick();
    settle();
    chk("m3_grant", grant, 4'b1000);
    chk("m3_stb", s_stb, 1'b1);
    rst_n = 1'b0;
    tick();
    settle();
    chk("midrst_cyc", s_cyc, 1'b0);
    chk("midrst_stb", s_stb, 1'b0);
    chk("midrst_grant", grant, 4'b0000);
    chk("midrst_adr", s_adr, 32'h0);
    rst_n = 1'b1;
    m_cyc = '1;
    m_stb = '1;
    tick();
    settle();
    chk("midrst_first_m0", grant, 4'b0001);
    m_cyc = '0;
    m_stb = '0;
    tick();

    // Slave never acks master 1; master 2 waits behind it
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h1000_0100, 32'h0);
    tick();
    settle();
    chk("wd_grant_m1", grant, 4'b0010);
    drive_m(2, 1'b1, 1'b1, 1'b0, 32'h2000_0100, 32'h0);
    chk("wd_err_c0", m_err, 4'b0000);
    for (int c = 1; c < 16; c++) begin
      tick();
      settle();
      chk($sformatf("wd_err_c%0d", c), m_err, 4'b0000);
      chk($sformatf("wd_stb_c%0d", c), s_stb, 1'b1);
    end
    tick();
    settle();
`ifdef WB_ARB_TIMEOUT_EN
    chk("wd_err_pulse", m_err, 4'b0010);
    chk("wd_stb_forced", s_stb, 1'b0);
    chk("wd_cyc_forced", s_cyc, 1'b0);
    tick();
    settle();
    chk("wd_err_one_cycle", m_err, 4'b0000);
    chk("wd_abort_stb", s_stb, 1'b0);
    chk("wd_abort_grant", grant, 4'b0010);
`else
    chk("wd_no_err", m_err, 4'b0000);
    chk("wd_still_stb", s_stb, 1'b1);
    chk("wd_still_grant", grant, 4'b0010);
`endif
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    settle();
    chk("wd_release", grant, 4'b0000);
    tick();
    settle();
    chk("wd_next_m2", grant, 4'b0100);
    chk("wd_next_adr", s_adr, 32'h2000_0100);
    drive_m(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Round-robin arbiter that shares the single-master Wishbone interconnect (`wb_intercon`) between NM Wishbone masters. It sits between the masters (CPU, DMA, debug) and the interconnect's master port. It holds a grant for the full duration of a master's `cyc` and routes `ack` and read data back only to the granted master. An optional watchdog aborts bus cycles that the slave never acknowledges.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; `SEL = DW/8`
- `NM`, 4, number of masters (2..8)
- `TIMEOUT`, 255, watchdog limit in cycles (used only with `WB_ARB_TIMEOUT_EN`)

- `wb_clk_i`  in  1  single clock; all logic on its rising edge
- `wb_rst_i`  in  1  synchronous reset, active-low
- `wbm_cyc_i`  in  NM  per-master cycle request
- `wbm_stb_i`  in  NM  per-master strobe
- `wbm_we_i`  in  NM  per-master write enable
- `wbm_sel_i`  in  NM*SEL  byte selects, master i at `[i*SEL +: SEL]`
- `wbm_adr_i`  in  NM*AW  addresses, packed the same way
- `wbm_dat_i`  in  NM*DW  write data, packed the same way
- `wbm_dat_o`  out  DW  read data, broadcast to all masters
- `wbm_ack_o`  out  NM  ack, granted master only
- `wbm_err_o`  out  NM  error/abort, granted master only
- `wbs_cyc_o`, `wbs_stb_o`, `wbs_we_o`  out  1  to interconnect
- `wbs_sel_o`  out  SEL; `wbs_adr_o` out AW; `wbs_dat_o` out DW  to interconnect
- `wbs_dat_i`  in  DW; `wbs_ack_i` in 1  from interconnect
- `grant_o`  out  NM  one-hot current grant (status)

## Operation
- FSM states: IDLE, GRANT, ABORT (ABORT exists only with the macro).
- IDLE: if any `wbm_cyc_i` is set, choose the first requester scanning upward from `last+1` (mod NM). Register the one-hot grant and go to GRANT. Otherwise stay in IDLE.
- GRANT: the slave-side signals are a combinational mux of the granted master's inputs. `wbs_cyc_o`/`wbs_stb_o` are ANDed with the grant. `wbm_ack_o[g] = wbs_ack_i`; all other acks are 0.
- GRANT exit: when `wbm_cyc_i[g]` falls, go to IDLE and set `last = g`. The grant is released in the same edge. Other masters' requests are ignored until the next IDLE arbitration.
- Burst/pipelined transfers are not split: multiple stb/ack pairs within one cyc all stay with the same master.
- `wbm_dat_o = wbs_dat_i` unconditionally. A master must qualify read data with its own ack.
- Reset: state IDLE, grant 0, `last = NM-1`, so master 0 wins first. Reset mid-cycle drops the grant immediately. All outputs are 0 from the reset edge, except `wbm_dat_o`, which tracks `wbs_dat_i`.

## Timing
- Arbitration latency: a request sampled at edge k produces `grant_o`/`wbs_cyc_o` high after edge k. The minimum is one cycle from request to slave `cyc`.
- Ack/err path is combinational, with zero added latency.
- A dead cycle follows each release. After `cyc` drops at edge k, state is IDLE; the next grant appears after edge k+1.
- Simultaneous requests: exactly one is granted, chosen by round-robin order. A requester waits at most NM-1 grants.
- Grant holder dropping `cyc` while another master raises it in the same cycle: the release happens first, then normal arbitration in IDLE.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears on each ack or on entry to GRANT, and increments each GRANT cycle with `wbs_stb_o` high and no ack.
  - When the counter reaches `TIMEOUT`, `wbm_err_o[g]` pulses for 1 cycle, `wbs_cyc_o`/`wbs_stb_o` are forced low, and the FSM moves to ABORT.
  - ABORT holds the slave side low until `wbm_cyc_i[g]` falls, then goes to IDLE and sets `last = g`.
- Not defined: no counter and no ABORT state. `wbm_err_o` is tied to 0 and the grant is held indefinitely.

## Structure
- Package `wb_arb_pkg`: FSM state enum, the default `TIMEOUT` constant, and a `clog2`-based index width for NM.
- Sub-module `wb_arb_rr_pick`: a combinational round-robin picker with inputs request vector and `last`, and outputs one-hot grant and index. It is reusable by other arbiters.
- Top level holds the FSM, the grant register, the muxes and the watchdog.

## Test plan
- Reset: drive `wb_rst_i=0` for 2 cycles with all cyc high -> all outputs 0, including `grant_o=0`. After release, `grant_o=4'b0001` after 1 cycle.
- Single master: master 2 writes `0x2300_0000 <= 0xDEADBEEF` then reads it back -> `wbs_adr_o` matches, `wbm_ack_o=4'b0100` only, read data `0xDEADBEEF`.
- Fairness: all 4 masters hold continuous requests, each doing one transfer per cyc -> grant sequence 0,1,2,3,0,1, with one dead cycle between grants.
- Burst hold: master 1 performs 4 stb/ack pairs in one cyc while master 0 requests -> all 4 acks go to master 1, and master 0 is granted only after master 1 drops cyc.
- Reset mid-cycle: assert reset while master 3 is granted with stb high -> `wbs_cyc_o=0` and `grant_o=0` after that edge. Master 0 is first after release.
- Timeout (macro on, `TIMEOUT=16`): slave never acks -> `wbm_err_o[g]` pulses exactly 16 cycles after stb, `wbs_stb_o` goes low, and the next master is granted after the holder drops cyc.
